// File: rtl/convolution_coprocessor_pkg.sv
// Convolution coprocessor shared types.
// Sequencer states and default datapath widths.
package convolution_coprocessor_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int LEN_W = DEF_ADDR_WIDTH + 1;
  localparam int Z_W   = DEF_ADDR_WIDTH + 1;
  localparam int IDX_W = DEF_ADDR_WIDTH + 3;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SCAN,
    DRAIN,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/convolution_coprocessor_index_check.sv
// H-index generation and range check for the sequencer.
// idxH = n - k; valid when non-negative and below sizeY.
module convolution_coprocessor_not (
  input  logic a_i,
  output logic y_o
);
  assign y_o = ~a_i;
endmodule

module convolution_coprocessor_index_check
  import convolution_coprocessor_pkg::*;
#(
  parameter int ZW = Z_W,
  parameter int KW = LEN_W,
  parameter int IW = IDX_W
) (
  input  logic [ZW-1:0] n_i,
  input  logic [KW-1:0] k_i,
  input  logic [KW-1:0] size_y_i,
  output logic [IW-1:0] idx_h_o,
  output logic          valid_o
);

  logic nonneg;
  logic in_len;

  assign idx_h_o = IW'(n_i) - IW'(k_i);
  assign in_len  = idx_h_o < IW'(size_y_i);

  convolution_coprocessor_not u_sign_not (
    .a_i (idx_h_o[IW-1]),
    .y_o (nonneg)
  );

  assign valid_o = nonneg & in_len;

endmodule

// File: rtl/convolution_coprocessor_sequencer.sv
// Convolution coprocessor control FSM.
// Walks n/k, issues X/H reads, drives MAC and Z writes.
module convolution_coprocessor_sequencer
  import convolution_coprocessor_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   size_x_i,
  input  logic [ADDR_WIDTH:0]   size_y_i,
  output logic [ADDR_WIDTH-1:0] addr_x_o,
  output logic [ADDR_WIDTH-1:0] addr_h_o,
  output logic                  mem_rd_o,
  output logic                  mac_clear_o,
  output logic                  mac_en_o,
  output logic [ADDR_WIDTH:0]   addr_z_o,
  output logic                  write_z_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam int ZW = ADDR_WIDTH + 1;
  localparam int IW = ADDR_WIDTH + 3;
  localparam int NW = ADDR_WIDTH + 2;

  state_e        state_q, state_d;
  logic [ZW-1:0] n_q, n_d;
  logic [LW-1:0] k_q, k_d;
  logic [LW-1:0] sx_q, sx_d;
  logic [LW-1:0] sy_q, sy_d;
  logic          mac_en_q;

  logic [NW-1:0] len_n;
  logic [IW-1:0] idx_h;
  logic          valid;
  logic          last_k;
  logic          last_n;
  logic          unused_idx;

  assign len_n  = NW'(sx_q) + NW'(sy_q) - NW'(1);
  assign last_k = k_q == sx_q - LW'(1);
  assign last_n = NW'(n_q) == len_n - NW'(1);

  convolution_coprocessor_index_check #(
    .ZW (ZW),
    .KW (LW),
    .IW (IW)
  ) u_idx (
    .n_i      (n_q),
    .k_i      (k_q),
    .size_y_i (sy_q),
    .idx_h_o  (idx_h),
    .valid_o  (valid)
  );

  assign unused_idx = ^idx_h[IW-1:ADDR_WIDTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      n_q      <= '0;
      k_q      <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      mac_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      k_q      <= k_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      mac_en_q <= mem_rd_o;
    end
  end

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    k_d         = k_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    mem_rd_o    = 1'b0;
    mac_clear_o = 1'b0;
    write_z_o   = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          sx_d = size_x_i;
          sy_d = size_y_i;
          n_d  = '0;
          // Empty operand: finish without touching memory.
          if (size_x_i != '0 && size_y_i != '0)
            state_d = CLEAR;
          else
            state_d = DONE;
        end
      end
      CLEAR: begin
        busy_o      = 1'b1;
        mac_clear_o = 1'b1;
        k_d         = '0;
        state_d     = SCAN;
      end
      SCAN: begin
        busy_o   = 1'b1;
        mem_rd_o = valid;
        if (last_k)
          state_d = DRAIN;
        else
          k_d = k_q + LW'(1);
      end
      DRAIN: begin
        busy_o  = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        busy_o    = 1'b1;
        write_z_o = 1'b1;
        if (last_n) begin
          state_d = DONE;
        end else begin
          n_d     = n_q + ZW'(1);
          state_d = CLEAR;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign addr_x_o = k_q[ADDR_WIDTH-1:0];
  assign addr_h_o = idx_h[ADDR_WIDTH-1:0];
  assign addr_z_o = n_q;
  assign mac_en_o = mac_en_q;

endmodule

// File: tb/tb_convolution_coprocessor_sequencer.sv
// Directed bench for the convolution sequencer.
// Start accepted at cycle 0; samples taken 1ns after each edge.
module tb_convolution_coprocessor_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] sx;
  logic [5:0] sy;
  logic [4:0] addr_x;
  logic [4:0] addr_h;
  logic       mem_rd;
  logic       mac_clear;
  logic       mac_en;
  logic [5:0] addr_z;
  logic       write_z;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;

  int n_rd, n_wr, n_clr, done_cyc, last_az;
  int rd_bad, wr_bad, mac_bad, busy_bad;
  int wr_after_rst, rst_snap;
  logic rd_t  [64];
  logic mac_t [64];
  logic clr_t [64];
  int   ax_t  [64];
  int   ah_t  [64];

  convolution_coprocessor_sequencer #(.ADDR_WIDTH(5)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .size_x_i    (sx),
    .size_y_i    (sy),
    .addr_x_o    (addr_x),
    .addr_h_o    (addr_h),
    .mem_rd_o    (mem_rd),
    .mac_clear_o (mac_clear),
    .mac_en_o    (mac_en),
    .addr_z_o    (addr_z),
    .write_z_o   (write_z),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  function automatic int outs();
    return int'({addr_x, addr_h, mem_rd, mac_clear,
                 mac_en, addr_z, write_z, busy, done});
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int x, input int y, input int budget,
                         input int pulse_c, input int rst_c);
    int   cyc;
    logic prev_rd;
    n_rd = 0; n_wr = 0; n_clr = 0;
    done_cyc = -1; last_az = -1;
    rd_bad = 0; wr_bad = 0; mac_bad = 0; busy_bad = 0;
    wr_after_rst = 0; rst_snap = -1;
    for (int i = 0; i < 64; i++) begin
      rd_t[i] = 1'b0; mac_t[i] = 1'b0; clr_t[i] = 1'b0;
      ax_t[i] = -1; ah_t[i] = -1;
    end
    prev_rd = 1'b0;
    cyc = 0;
    sx = x[5:0];
    sy = y[5:0];
    start = 1'b1;
    while (cyc < budget && done_cyc < 0) begin
      step();
      cyc++;
      start = (cyc == pulse_c);
      rst = (cyc == rst_c);
      if (cyc == 1) begin
        sx = 6'd9;
        sy = 6'd0;
      end
      if (cyc < 64) begin
        rd_t[cyc] = mem_rd; mac_t[cyc] = mac_clear ? 1'b0 : mac_en;
        mac_t[cyc] = mac_en; clr_t[cyc] = mac_clear;
        ax_t[cyc] = int'(addr_x); ah_t[cyc] = int'(addr_h);
      end
      if (rst_c >= 0 && cyc == rst_c + 1)
        rst_snap = outs();
      else if (mac_en !== prev_rd)
        mac_bad++;
      prev_rd = mem_rd;
      if (mem_rd) begin
        n_rd++;
        if (int'(addr_x) + int'(addr_h) != n_wr || int'(addr_h) >= y)
          rd_bad++;
      end
      if (mac_clear) n_clr++;
      if (write_z) begin
        if (int'(addr_z) != n_wr) wr_bad++;
        last_az = int'(addr_z);
        n_wr++;
        if (rst_c >= 0 && cyc > rst_c) wr_after_rst++;
      end
      if (rst_c < 0) begin
        if (done) begin
          if (busy !== 1'b0) busy_bad++;
        end else if (busy !== 1'b1) begin
          busy_bad++;
        end
      end
      if (done) done_cyc = cyc;
    end
    start = 1'b0;
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    sx = 6'd3;
    sy = 6'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("reset_outs_%0d", i), outs(), 0);
    end
    rst = 1'b0;
    start = 1'b0;
    step();
    chk("idle_outs", outs(), 0);

    run_job(3, 2, 60, -1, -1);
    chk("t2_clear_c1", int'(clr_t[1]), 1);
    chk("t2_n0_rd", int'({rd_t[2], rd_t[3], rd_t[4]}), 3'b100);
    chk("t2_n0_h", ah_t[2], 0);
    chk("t2_n2_rd", int'({rd_t[14], rd_t[15], rd_t[16]}), 3'b011);
    chk("t2_n2_x1", ax_t[15], 1);
    chk("t2_n2_h1", ah_t[15], 1);
    chk("t2_n2_x2", ax_t[16], 2);
    chk("t2_n2_h2", ah_t[16], 0);
    chk("t2_reads", n_rd, 6);
    chk("t2_writes", n_wr, 4);
    chk("t2_last_z", last_az, 3);
    chk("t2_wr_addr", wr_bad, 0);
    chk("t2_rd_addr", rd_bad, 0);
    chk("t2_mac_en", mac_bad, 0);
    chk("t2_clears", n_clr, 4);
    chk("t2_busy", busy_bad, 0);
    chk("t2_done", done_cyc, 25);

    run_job(0, 5, 10, -1, -1);
    chk("t3_done", done_cyc, 1);
    chk("t3_reads", n_rd, 0);
    chk("t3_writes", n_wr, 0);
    chk("t3_busy", busy_bad, 0);

    run_job(1, 1, 10, -1, -1);
    chk("t4_rd_c2", int'(rd_t[2]), 1);
    chk("t4_x_c2", ax_t[2], 0);
    chk("t4_h_c2", ah_t[2], 0);
    chk("t4_mac_c3", int'(mac_t[3]), 1);
    chk("t4_reads", n_rd, 1);
    chk("t4_writes", n_wr, 1);
    chk("t4_last_z", last_az, 0);
    chk("t4_done", done_cyc, 5);

    run_job(3, 2, 30, 8, 10);
    chk("t5_rd_c9", int'(rd_t[9]), 1);
    chk("t5_x_c9", ax_t[9], 1);
    chk("t5_clr_c9", int'(clr_t[9]), 0);
    chk("t5_rst_outs", rst_snap, 0);
    chk("t5_writes", n_wr, 1);
    chk("t5_wr_post", wr_after_rst, 0);
    chk("t5_no_done", done_cyc, -1);
    run_job(1, 1, 10, -1, -1);
    chk("t5_fresh_done", done_cyc, 5);
    chk("t5_fresh_wr", n_wr, 1);

    run_job(32, 32, 2300, -1, -1);
    chk("t6_writes", n_wr, 63);
    chk("t6_last_z", last_az, 62);
    chk("t6_reads", n_rd, 1024);
    chk("t6_rd_addr", rd_bad, 0);
    chk("t6_wr_addr", wr_bad, 0);
    chk("t6_mac_en", mac_bad, 0);
    chk("t6_busy", busy_bad, 0);
    chk("t6_done", done_cyc, 2206);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
